// File: rtl/riscv_wb_arbiter.sv
// Register-file writeback arbiter: round-robin selection among NUM_REQ
// writeback sources, one registered write per cycle to the single write
// port, a pending-destination bitmap and a committed-write counter.
module riscv_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [ADDR_W-1:0]         rd_addr_o,
  output logic                      wr_en_o,
  output logic [XLEN-1:0]           wr_data_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [31:0]               pend_o,
  output logic [CNT_W-1:0]          wb_count_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  // Advance a requester index with wrap from the last requester back to 0.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [XLEN-1:0]   data_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k] = req_rd_addr_i[k*ADDR_W +: ADDR_W];
    assign data_arr[k] = req_data_i[k*XLEN +: XLEN];
  end

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   scan_p0;
  logic [PTR_W-1:0]   sel_p0;
  logic               hit_p0;
  logic [NUM_REQ-1:0] gnt_p0;
  logic [ADDR_W-1:0]  sel_addr_p0;
  logic [XLEN-1:0]    sel_data_p0;

  logic               vld_p1;
  logic [NUM_REQ-1:0] grant_p1;
  logic [ADDR_W-1:0]  rd_addr_p1;
  logic [XLEN-1:0]    wr_data_p1;
  logic [CNT_W-1:0]   cnt_p1;

  // ---- stage p0: round-robin selection, starting the scan at rr_ptr ----
  // Pick the first valid requester at or after rr_ptr (wrapping).
  always_comb begin
    hit_p0  = 1'b0;
    sel_p0  = rr_ptr;
    scan_p0 = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit_p0 && req_valid_i[scan_p0]) begin
        hit_p0 = 1'b1;
        sel_p0 = scan_p0;
      end
      scan_p0 = ptr_inc(scan_p0);
    end
    gnt_p0 = '0;
    if (hit_p0) gnt_p0[sel_p0] = 1'b1;
    sel_addr_p0 = addr_arr[sel_p0];
    sel_data_p0 = data_arr[sel_p0];
  end

  // Ready is the grant itself, forced low while reset is held.
  assign req_ready_o = reset ? '0 : gnt_p0;

  // ---- stage p1: registered write presented to the register file ----
  // Capture the winner, advance the pointer and count committed writes.
  // A write to x0 completes the handshake but never enables the port, and
  // address/data hold so the port stays quiet on idle or x0 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      vld_p1     <= 1'b0;
      grant_p1   <= '0;
      rd_addr_p1 <= '0;
      wr_data_p1 <= '0;
      cnt_p1     <= '0;
    end else begin
      vld_p1   <= hit_p0 && (sel_addr_p0 != '0);
      grant_p1 <= gnt_p0;
      if (hit_p0) begin
        rr_ptr <= ptr_inc(sel_p0);
        if (sel_addr_p0 != '0) begin
          rd_addr_p1 <= sel_addr_p0;
          wr_data_p1 <= sel_data_p0;
        end
      end
      if (vld_p1) cnt_p1 <= cnt_p1 + 1'b1;
    end
  end

  // Pending-destination bitmap decoded from the output stage.
  always_comb begin
    pend_o = '0;
    if (vld_p1) pend_o[rd_addr_p1] = 1'b1;
  end

  assign wr_en_o    = vld_p1;
  assign rd_addr_o  = rd_addr_p1;
  assign wr_data_o  = wr_data_p1;
  assign grant_o    = grant_p1;
  assign wb_count_o = cnt_p1;

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Testbench for riscv_wb_arbiter: directed scenarios followed by random
// traffic, compared against a transaction-level reference model.
module tb_riscv_wb_arbiter;

  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 4;

  logic                      clk = 1'b0;
  logic                      reset = 1'b1;
  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr_i;
  logic [NUM_REQ*XLEN-1:0]   req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic [ADDR_W-1:0]         rd_addr_o;
  logic                      wr_en_o;
  logic [XLEN-1:0]           wr_data_o;
  logic [NUM_REQ-1:0]        grant_o;
  logic [31:0]               pend_o;
  logic [CNT_W-1:0]          wb_count_o;

  riscv_wb_arbiter #(
    .NUM_REQ(NUM_REQ), .XLEN(XLEN), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_rd_addr_i(req_rd_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o), .rd_addr_o(rd_addr_o), .wr_en_o(wr_en_o),
    .wr_data_o(wr_data_o), .grant_o(grant_o), .pend_o(pend_o), .wb_count_o(wb_count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester-side transactions
  int               m_ptr;
  logic             m_v [NUM_REQ];
  logic [ADDR_W-1:0] m_a [NUM_REQ];
  logic [XLEN-1:0]  m_d [NUM_REQ];
  // Expected write-port state for the current cycle
  logic             e_wen;
  logic [ADDR_W-1:0] e_addr;
  logic [XLEN-1:0]  e_data;
  int               e_grant;
  int               e_cnt;
  // Expected and observed register file contents
  logic [XLEN-1:0]  rf [32];
  logic [XLEN-1:0]  dut_rf [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int winner();
    for (int i = 0; i < NUM_REQ; i++) begin
      int k;
      k = (m_ptr + i) % NUM_REQ;
      if (m_v[k]) return k;
    end
    return -1;
  endfunction

  task automatic drive();
    for (int k = 0; k < NUM_REQ; k++) begin
      req_valid_i[k] = m_v[k];
      req_rd_addr_i[k*ADDR_W +: ADDR_W] = m_a[k];
      req_data_i[k*XLEN +: XLEN] = m_d[k];
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; e_wen = 1'b0; e_addr = '0; e_data = '0; e_grant = 0; e_cnt = 0;
  endtask

  task automatic check_outputs();
    int w;
    w = winner();
    chk("ready", 64'(req_ready_o), (w < 0) ? 64'd0 : (64'd1 << w));
    chk("wr_en", 64'(wr_en_o), 64'(e_wen));
    chk("rd_addr", 64'(rd_addr_o), 64'(e_addr));
    chk("wr_data", 64'(wr_data_o), 64'(e_data));
    chk("grant", 64'(grant_o), 64'(e_grant));
    chk("pend", 64'(pend_o), e_wen ? (64'd1 << e_addr) : 64'd0);
    chk("count", 64'(wb_count_o), 64'(e_cnt));
    if (wr_en_o === 1'b1) dut_rf[rd_addr_o] = wr_data_o;
  endtask

  task automatic model_edge();
    int w;
    w = winner();
    if (e_wen) begin
      rf[e_addr] = e_data;
      e_cnt = (e_cnt + 1) % (1 << CNT_W);
    end
    if (w >= 0) begin
      e_grant = 1 << w;
      e_wen = (m_a[w] != 0);
      if (m_a[w] != 0) begin
        e_addr = m_a[w];
        e_data = m_d[w];
      end
      m_ptr = (w + 1) % NUM_REQ;
      m_v[w] = 1'b0;
    end else begin
      e_wen = 1'b0;
      e_grant = 0;
    end
  endtask

  // One clock: check mid-cycle, advance model at the edge, redrive after it.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
    drive();
  endtask

  task automatic request(input int k, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
    m_v[k] = 1'b1; m_a[k] = a; m_d[k] = d;
  endtask

  initial begin
    for (int k = 0; k < NUM_REQ; k++) begin
      m_v[k] = 1'b0; m_a[k] = '0; m_d[k] = '0;
    end
    for (int r = 0; r < 32; r++) begin
      rf[r] = '0; dut_rf[r] = '0;
    end
    model_reset();
    drive();

    // Power-up reset, checked while reset is held
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 64'(wr_en_o), 64'd0);
    chk("rst_count", 64'(wb_count_o), 64'd0);
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_addr", 64'(rd_addr_o), 64'd0);
    chk("rst_data", 64'(wr_data_o), 64'd0);
    reset = 1'b0;
    cycle();
    cycle();

    // Single request from requester 1
    request(1, 5'd5, 32'hDEADBEEF);
    drive();
    #1;
    chk("t2_ready", 64'(req_ready_o), 64'h2);
    cycle();
    chk("t2_wr_en", 64'(wr_en_o), 64'd1);
    chk("t2_addr", 64'(rd_addr_o), 64'd5);
    chk("t2_data", 64'(wr_data_o), 64'hDEADBEEF);
    chk("t2_grant", 64'(grant_o), 64'h2);
    chk("t2_pend", 64'(pend_o), 64'h20);
    cycle();
    chk("t2_count", 64'(wb_count_o), 64'd1);

    // Same destination from requesters 0 and 2 with the pointer at 2
    request(0, 5'd7, 32'h11);
    request(2, 5'd7, 32'h22);
    drive();
    #1;
    chk("t5_first", 64'(req_ready_o), 64'h4);
    repeat (4) cycle();
    chk("t5_rf7", 64'(dut_rf[7]), 64'h11);

    // Write to x0 from requester 0
    request(0, 5'd0, 32'h1234);
    drive();
    #1;
    chk("t4_ready", 64'(req_ready_o), 64'h1);
    chk("t4_count_before", 64'(wb_count_o), 64'd3);
    cycle();
    chk("t4_wr_en", 64'(wr_en_o), 64'd0);
    chk("t4_pend", 64'(pend_o), 64'd0);
    chk("t4_grant", 64'(grant_o), 64'h1);
    cycle();
    chk("t4_count_after", 64'(wb_count_o), 64'd3);
    // Pointer is now 1: requester 1 must win over requester 0
    request(0, 5'd3, 32'hA0);
    request(1, 5'd4, 32'hA1);
    drive();
    #1;
    chk("t4_ptr1", 64'(req_ready_o), 64'h2);
    repeat (4) cycle();

    // Reset asserted mid-cycle while a write sits in the output stage
    request(2, 5'd9, 32'hBAD0BAD0);
    drive();
    cycle();
    chk("t1_pending", 64'(wr_en_o), 64'd1);
    request(1, 5'd6, 32'h66);
    drive();
    #1;
    reset = 1'b1;
    #1;
    chk("t1_wr_en", 64'(wr_en_o), 64'd0);
    chk("t1_grant", 64'(grant_o), 64'd0);
    chk("t1_pend", 64'(pend_o), 64'd0);
    chk("t1_count", 64'(wb_count_o), 64'd0);
    chk("t1_ready", 64'(req_ready_o), 64'd0);
    m_v[1] = 1'b0;
    drive();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) cycle();
    chk("t1_no_write", 64'(dut_rf[9]), 64'd0);

    // All three requesters continuously valid from pointer 0
    for (int k = 0; k < NUM_REQ; k++) request(k, ADDR_W'(10 + k), XLEN'(32'hC0 + k));
    drive();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("t3_grant_seq", 64'(req_ready_o), 64'd1 << (i % NUM_REQ));
      cycle();
      if (i < 3) begin
        request(i, ADDR_W'(13 + i), XLEN'(32'hD0 + i));
        drive();
      end
    end
    cycle();
    chk("t3_count", 64'(wb_count_o), 64'd6);
    cycle();

    // Counter wrap at 4 bits
    reset = 1'b1;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      request(0, ADDR_W'(1 + (i % 31)), XLEN'(i));
      drive();
      cycle();
    end
    chk("t6_wrap0", 64'(wb_count_o), 64'd0);
    cycle();
    chk("t6_wrap1", 64'(wb_count_o), 64'd1);
    cycle();

    // Random traffic with frequent address collisions and x0 writes
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!m_v[k] && ($urandom_range(0, 1) == 1)) begin
          if ($urandom_range(0, 3) == 0) request(k, ADDR_W'($urandom_range(0, 31)), $urandom);
          else request(k, ADDR_W'($urandom_range(0, 7)), $urandom);
        end
      end
      drive();
      cycle();
    end
    for (int k = 0; k < NUM_REQ; k++) m_v[k] = 1'b0;
    drive();
    repeat (3) cycle();
    for (int r = 0; r < 32; r++) chk($sformatf("rf_x%0d", r), 64'(dut_rf[r]), 64'(rf[r]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
